// File: rtl/rf_wport_sched_pkg.sv
// Shared constants for the register-file write-port scheduler: register file
// geometry, boolean constants, starvation FSM encoding and its default limit.
package rf_wport_sched_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 4;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } starve_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register marking an
// outstanding long-latency write. Register 0 can never be marked pending.
module rf_scoreboard
  import rf_wport_sched_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set,
  input  logic [REG_AW-1:0]   i_set_idx,
  input  logic                i_clr,
  input  logic [REG_AW-1:0]   i_clr_idx,
  input  logic [REG_AW-1:0]   i_lk1_idx,
  input  logic [REG_AW-1:0]   i_lk2_idx,
  input  logic [REG_AW-1:0]   i_lk3_idx,
  output logic                o_lk1_pend,
  output logic                o_lk2_pend,
  output logic                o_lk3_pend,
  output logic [NUM_REGS-1:0] o_pend
);

  localparam logic [NUM_REGS-1:0] NO_ZERO_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_pend_nxt;

  // Build set/clear masks; the set is applied after the clear so it wins on a collision.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set && (i_set_idx != ZERO_REG)) w_set_mask[i_set_idx] = TRUE;
    if (i_clr)                            w_clr_mask[i_clr_idx] = TRUE;
    w_pend_nxt = ((r_pend & ~w_clr_mask) | w_set_mask) & NO_ZERO_MASK;
  end

  // Pending-bit register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  assign o_lk1_pend = r_pend[i_lk1_idx];
  assign o_lk2_pend = r_pend[i_lk2_idx];
  assign o_lk3_pend = r_pend[i_lk3_idx];
  assign o_pend     = r_pend;

endmodule

// File: rtl/rf_wport_sched.sv
// Write-port scheduler for the 32x32 register file. The in-order writeback
// always owns the port when it writes; the long-latency unit takes the port
// otherwise. Outstanding long-latency destinations are tracked to stall decode
// on RAW/WAW hazards, and a starvation FSM forces a stall when the
// long-latency result has been refused for too long, draining writeback.
//
// Long-latency handshake: a result transfers in every cycle where
// i_ll_valid and o_ll_ready are both high. o_ll_ready is combinational,
// never depends on a prior handshake, and the source may hold or drop
// i_ll_valid freely while not accepted.
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  input  logic              i_ll_valid,
  input  logic [REG_AW-1:0] i_ll_waddr,
  input  logic [DATA_W-1:0] i_ll_wdata,
  output logic              o_ll_ready,
  input  logic              i_iss_valid,
  input  logic [REG_AW-1:0] i_iss_dest,
  input  logic              i_re1,
  input  logic [REG_AW-1:0] i_r1addr,
  input  logic              i_re2,
  input  logic [REG_AW-1:0] i_r2addr,
  input  logic              i_id_we,
  input  logic [REG_AW-1:0] i_id_dest,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_stall,
  output logic              o_busy,
  output starve_state_e     o_dbg_state
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic                r_starve;
  logic [CNT_W-1:0]    r_wait_cnt;
  starve_state_e       r_state;
  starve_state_e       w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_starve_nxt;
  logic                w_ll_ready;
  logic                w_p1;
  logic                w_p2;
  logic                w_p3;
  logic                w_raw;
  logic                w_waw;
  logic                w_stall;
  logic                w_set;
  logic                w_clr;
  logic [NUM_REGS-1:0] w_pend;

  // Write-port arbitration: writeback first, long-latency result otherwise.
  always_comb begin
    w_ll_ready = FALSE;
    o_rf_we    = FALSE;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    if (i_wb_we) begin
      o_rf_we    = TRUE;
      o_rf_waddr = i_wb_waddr;
      o_rf_wdata = i_wb_wdata;
    end else if (i_ll_valid) begin
      w_ll_ready = TRUE;
      o_rf_we    = TRUE;
      o_rf_waddr = i_ll_waddr;
      o_rf_wdata = i_ll_wdata;
    end
  end

  assign o_ll_ready = w_ll_ready;

  rf_scoreboard u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (w_set),
    .i_set_idx  (i_iss_dest),
    .i_clr      (w_clr),
    .i_clr_idx  (i_ll_waddr),
    .i_lk1_idx  (i_r1addr),
    .i_lk2_idx  (i_r2addr),
    .i_lk3_idx  (i_id_dest),
    .o_lk1_pend (w_p1),
    .o_lk2_pend (w_p2),
    .o_lk3_pend (w_p3),
    .o_pend     (w_pend)
  );

  assign w_raw   = (i_re1 & w_p1) | (i_re2 & w_p2);
  assign w_waw   = i_id_we & w_p3;
  assign w_stall = w_raw | w_waw | r_starve;
  assign w_set   = i_iss_valid & ~w_stall & (i_iss_dest != ZERO_REG);
  assign w_clr   = i_ll_valid & w_ll_ready;

  assign o_stall     = w_stall;
  assign o_busy      = |w_pend;
  assign o_dbg_state = r_state;

  // Starvation FSM next state: count consecutive refusals, leave on handshake or withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_ll_valid && !w_ll_ready) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!i_ll_valid || w_ll_ready) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_wait_cnt != '1) begin
          w_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_starve_nxt = (w_state_nxt == ST_WAIT) && (w_cnt_nxt >= LIMIT_C);
  end

  // Starvation FSM state, refusal counter and registered starve flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_starve   <= FALSE;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_starve   <= w_starve_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Bench for rf_wport_sched: directed scenarios followed by random traffic,
// all checked against a behavioural model of the scheduler's rules.
module tb_rf_wport_sched;
  import rf_wport_sched_pkg::*;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        llv;
    logic [4:0]  lla;
    logic [31:0] lld;
    logic        iss;
    logic [4:0]  isd;
    logic        re1;
    logic [4:0]  a1;
    logic        re2;
    logic [4:0]  a2;
    logic        idwe;
    logic [4:0]  idd;
  } stim_t;

  logic          clk;
  logic          rst;
  logic          i_wb_we;
  logic [4:0]    i_wb_waddr;
  logic [31:0]   i_wb_wdata;
  logic          i_ll_valid;
  logic [4:0]    i_ll_waddr;
  logic [31:0]   i_ll_wdata;
  logic          o_ll_ready;
  logic          i_iss_valid;
  logic [4:0]    i_iss_dest;
  logic          i_re1;
  logic [4:0]    i_r1addr;
  logic          i_re2;
  logic [4:0]    i_r2addr;
  logic          i_id_we;
  logic [4:0]    i_id_dest;
  logic          o_rf_we;
  logic [4:0]    o_rf_waddr;
  logic [31:0]   o_rf_wdata;
  logic          o_stall;
  logic          o_busy;
  starve_state_e o_dbg_state;

  // Expected register-file writes, {addr, data}, in issue order.
  logic [36:0] exp_q[$];

  // Reference model: set of pending registers and the current refusal streak.
  bit pend_m[32];
  int streak;
  bit starve_m;

  int n_checks = 0;
  int n_pass   = 0;

  rf_wport_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_we     (i_wb_we),
    .i_wb_waddr  (i_wb_waddr),
    .i_wb_wdata  (i_wb_wdata),
    .i_ll_valid  (i_ll_valid),
    .i_ll_waddr  (i_ll_waddr),
    .i_ll_wdata  (i_ll_wdata),
    .o_ll_ready  (o_ll_ready),
    .i_iss_valid (i_iss_valid),
    .i_iss_dest  (i_iss_dest),
    .i_re1       (i_re1),
    .i_r1addr    (i_r1addr),
    .i_re2       (i_re2),
    .i_r2addr    (i_r2addr),
    .i_id_we     (i_id_we),
    .i_id_dest   (i_id_dest),
    .o_rf_we     (o_rf_we),
    .o_rf_waddr  (o_rf_waddr),
    .o_rf_wdata  (o_rf_wdata),
    .o_stall     (o_stall),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    i_wb_we     = s.wb_we;
    i_wb_waddr  = s.wb_a;
    i_wb_wdata  = s.wb_d;
    i_ll_valid  = s.llv;
    i_ll_waddr  = s.lla;
    i_ll_wdata  = s.lld;
    i_iss_valid = s.iss;
    i_iss_dest  = s.isd;
    i_re1       = s.re1;
    i_r1addr    = s.a1;
    i_re2       = s.re2;
    i_r2addr    = s.a2;
    i_id_we     = s.idwe;
    i_id_dest   = s.idd;
  endtask

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    streak   = 0;
    starve_m = 1'b0;
  endtask

  // Drive one cycle (called at posedge+1), check at negedge, advance model at posedge.
  task automatic cycle(input stim_t s);
    bit st_e;
    bit rdy_e;
    bit we_e;
    bit busy_e;
    apply(s);
    st_e   = (s.re1 && pend_m[s.a1]) || (s.re2 && pend_m[s.a2]) ||
             (s.idwe && pend_m[s.idd]) || starve_m;
    rdy_e  = s.llv && !s.wb_we;
    busy_e = 1'b0;
    foreach (pend_m[i]) busy_e |= pend_m[i];
    we_e = s.wb_we || s.llv;
    if (s.wb_we)    exp_q.push_back({s.wb_a, s.wb_d});
    else if (s.llv) exp_q.push_back({s.lla, s.lld});
    @(negedge clk);
    chk("stall", 64'(o_stall), 64'(st_e));
    chk("ll_ready", 64'(o_ll_ready), 64'(rdy_e));
    chk("busy", 64'(o_busy), 64'(busy_e));
    chk("rf_we", 64'(o_rf_we), 64'(we_e));
    chk("dbg_state", 64'(o_dbg_state), 64'(streak > 0));
    if (!we_e) chk("idle_port", {27'd0, o_rf_waddr, o_rf_wdata}, 64'd0);
    @(posedge clk);
    if (rdy_e) pend_m[s.lla] = 1'b0;
    if (s.iss && !st_e && s.isd != 5'd0) pend_m[s.isd] = 1'b1;
    if (s.llv && s.wb_we) streak++;
    else                  streak = 0;
    starve_m = (streak >= LIMIT);
    #1;
  endtask

  // Scoreboard monitor: every write the port presents must match the next expected one.
  always @(negedge clk) begin
    logic [36:0] e;
    if (o_rf_we) begin
      if (exp_q.size() == 0) begin
        chk("rf_write_unexpected", {27'd0, o_rf_waddr, o_rf_wdata}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, o_rf_waddr, o_rf_wdata}, {27'd0, e});
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s.wb_we = ($urandom_range(0, 1) == 1);
    s.wb_a  = 5'($urandom_range(0, 31));
    s.wb_d  = $urandom;
    s.llv   = ($urandom_range(0, 9) < 6);
    s.lla   = 5'($urandom_range(0, 7));
    s.lld   = $urandom;
    s.iss   = ($urandom_range(0, 9) < 3);
    s.isd   = 5'($urandom_range(0, 7));
    s.re1   = ($urandom_range(0, 1) == 1);
    s.a1    = 5'($urandom_range(0, 7));
    s.re2   = ($urandom_range(0, 1) == 1);
    s.a2    = 5'($urandom_range(0, 7));
    s.idwe  = ($urandom_range(0, 1) == 1);
    s.idd   = 5'($urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1;
    apply(idle());
    model_reset();

    // Reset state.
    #2;
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_rf_we", 64'(o_rf_we), 64'd0);
    chk("rst_ll_ready", 64'(o_ll_ready), 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'd0);
    #1 i_ll_valid = 1'b1;
    #1 chk("rst_ll_ready_follows", 64'(o_ll_ready), 64'd1);
    i_ll_valid = 1'b0;
    #8 rst = 1'b0;
    @(posedge clk);
    #1;

    // Issue and complete r5, then a dependent read one cycle later.
    s = idle(); s.iss = 1; s.isd = 5'd5; cycle(s);
    s = idle(); s.re1 = 1; s.a1 = 5'd5; cycle(s);
    s = idle(); s.llv = 1; s.lla = 5'd5; s.lld = 32'hDEADBEEF; cycle(s);
    s = idle(); s.re1 = 1; s.a1 = 5'd5; cycle(s);

    // Writeback priority over a waiting long-latency result.
    s = idle(); s.wb_we = 1; s.wb_a = 5'd3; s.wb_d = 32'h11;
    s.llv = 1; s.lla = 5'd8; s.lld = 32'h88; cycle(s);
    s = idle(); s.llv = 1; s.lla = 5'd8; s.lld = 32'h88; cycle(s);

    // Starvation: six refused cycles, then the handshake, then recovery.
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.wb_we = 1; s.wb_a = 5'(i + 1); s.wb_d = 32'(i * 3);
      s.llv = 1; s.lla = 5'd10; s.lld = 32'hCAFE; cycle(s);
    end
    s = idle(); s.llv = 1; s.lla = 5'd10; s.lld = 32'hCAFE; cycle(s);
    cycle(idle());

    // Register zero is never pending; WAW stall blocks a simultaneous issue.
    s = idle(); s.iss = 1; s.isd = 5'd0; cycle(s);
    s = idle(); s.re1 = 1; s.a1 = 5'd0; cycle(s);
    s = idle(); s.iss = 1; s.isd = 5'd7; cycle(s);
    s = idle(); s.idwe = 1; s.idd = 5'd7; s.iss = 1; s.isd = 5'd11; cycle(s);
    s = idle(); s.re1 = 1; s.a1 = 5'd11; cycle(s);
    s = idle(); s.llv = 1; s.lla = 5'd7; s.lld = 32'h77; cycle(s);

    // Read-enable gating.
    s = idle(); s.iss = 1; s.isd = 5'd12; cycle(s);
    s = idle(); s.re2 = 0; s.a2 = 5'd12; cycle(s);
    s = idle(); s.re2 = 1; s.a2 = 5'd12; cycle(s);
    s = idle(); s.llv = 1; s.lla = 5'd12; s.lld = 32'h12; cycle(s);

    // Reset mid-operation with r4, r9 pending and two refusals counted.
    s = idle(); s.iss = 1; s.isd = 5'd4; cycle(s);
    s = idle(); s.iss = 1; s.isd = 5'd9; cycle(s);
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.wb_we = 1; s.wb_a = 5'd1; s.wb_d = 32'h5;
      s.llv = 1; s.lla = 5'd20; s.lld = 32'h20; cycle(s);
    end
    apply(idle());
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_stall", 64'(o_stall), 64'd0);
    chk("midrst_rf_we", 64'(o_rf_we), 64'd0);
    chk("midrst_state", 64'(o_dbg_state), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    s = idle(); s.re1 = 1; s.a1 = 5'd4; s.re2 = 1; s.a2 = 5'd9; cycle(s);

    // Random traffic.
    for (int i = 0; i < 400; i++) cycle(rand_stim());

    cycle(idle());
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
